// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: digit-serial BCD adder/subtractor, one digit per cycle.
// Define BCD_SIGNED_EN to add the FIX pass that returns sign-magnitude results on negative subtraction.
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   s,
    output logic                  cy,
    output logic                  neg,
    output logic                  err
);
    localparam int W = 4*DIGITS;

    typedef enum logic [2:0] {IDLE, CHECK, ADD, FIX, DONE} state_t;

    state_t       state, nxt;
    logic [W-1:0] ra, rb;
    logic         opr, c, bad, dc, last, fix_go;
    logic [3:0]   cnt, x, y, dsum;
    logic [4:0]   t;

    function automatic logic has_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) r = r | (v[4*i+:4] > 4'd9);
        return r;
    endfunction

    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i+:4] = 4'd9 - v[4*i+:4];
        return r;
    endfunction

    assign busy = state != IDLE;
    assign done = state == DONE;

    // One shared digit adder: ADD consumes ra/rb, FIX adds carry to the 9's complement of s
    always_comb begin
        x    = state == FIX ? 4'd9 - s[3:0] : ra[3:0];
        y    = state == FIX ? 4'd0 : rb[3:0];
        t    = {1'b0, x} + {1'b0, y} + {4'b0, c};
        dc   = t > 5'd9;
        dsum = dc ? 4'(t + 5'd6) : t[3:0];
        last = cnt == 4'(DIGITS-1);
`ifdef BCD_SIGNED_EN
        fix_go = opr & ~dc;
`else
        fix_go = 1'b0;
`endif
        nxt = state;
        case (state)
            IDLE:    nxt = start ? CHECK : IDLE;
            CHECK:   nxt = bad ? DONE : ADD;
            ADD:     nxt = last ? (fix_go ? FIX : DONE) : ADD;
            FIX:     nxt = last ? DONE : FIX;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            opr   <= 1'b0;
            c     <= 1'b0;
            bad   <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cy    <= 1'b0;
            err   <= 1'b0;
`ifdef BCD_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (start) begin
                    ra  <= a;
                    rb  <= op ? nines(b) : b;
                    opr <= op;
                    c   <= op;
                    bad <= has_bad(a) | has_bad(b);
                    cnt <= '0;
                    s   <= '0;
                    cy  <= 1'b0;
                    err <= 1'b0;
`ifdef BCD_SIGNED_EN
                    neg <= 1'b0;
`endif
                end
                CHECK: if (bad) err <= 1'b1;
                ADD: begin
                    s   <= W'({dsum, s} >> 4);
                    ra  <= ra >> 4;
                    rb  <= rb >> 4;
                    c   <= last ? 1'b1 : dc;
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                    if (last) cy <= opr ? ~dc : dc;
                end
`ifdef BCD_SIGNED_EN
                FIX: begin
                    s   <= W'({dsum, s} >> 4);
                    c   <= dc;
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                    neg <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef BCD_SIGNED_EN
    assign neg = 1'b0;
`endif
endmodule

// File: doc/bcd_addsub_seq.md
BCD_ADDSUB_SEQ -- requirements
Module: bcd_addsub_seq

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand (legal range 1..8).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 nrst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005 op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 a  input  4*DIGITS  BCD minuend/augend; digit 0 is in bits [3:0]; sampled with start.
REQ-007 b  input  4*DIGITS  BCD subtrahend/addend; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when s, cy, neg and err are valid.
REQ-010 s  output  4*DIGITS  BCD result; held from done until the next accepted start.
REQ-011 cy  output  1  add: decimal carry-out (overflow); subtract: borrow (a<b).
REQ-012 neg  output  1  result is negative magnitude (only when BCD_SIGNED_EN is defined).
REQ-013 err  output  1  a or b held a digit >9 when start was accepted.

Function
REQ-014 The FSM SHALL have states IDLE, CHECK, ADD, FIX and DONE.
REQ-015 IDLE with start=1 SHALL latch a, op and either b (op=0) or the digit-wise 9's complement of b (op=1), set the carry register to op, and go to CHECK.
REQ-016 CHECK SHALL last one cycle: if any latched source digit is >9, set err=1, s=0, cy=0, neg=0, and go to DONE; otherwise go to ADD.
REQ-017 ADD SHALL process one digit per cycle, LSD first: binary 4-bit sum plus carry, +6 correction when the sum exceeds 9, and digit carry forwarded to the next digit.
REQ-018 ADD SHALL last exactly DIGITS cycles; the final digit carry is c_out.
REQ-019 After ADD, op=0 SHALL give cy=c_out, and op=1 SHALL give cy=~c_out.
REQ-020 After ADD, the block SHALL go to FIX only when BCD_SIGNED_EN is defined, op=1 and cy=1; otherwise it SHALL go to DONE.
REQ-021 FIX SHALL take DIGITS cycles, one per digit, replacing s with the 9's complement of s plus 1 (carry-in 1), giving |a-b|, and SHALL set neg=1.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 Latency, counted in rising edges from the edge that samples start to the first edge at which done is high:
- DIGITS+2 for a normal operation;
- 2*DIGITS+2 when FIX runs;
- 2 on err.
REQ-024 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-025 start held high continuously SHALL begin a new operation on the cycle after DONE; back-to-back throughput is one operation per latency+1 cycles.
REQ-026 s, cy, neg and err SHALL change only at acceptance (cleared to 0) and during CHECK, ADD, FIX or DONE of the current operation.
REQ-027 Digit arithmetic SHALL wrap modulo 10^DIGITS; there SHALL be no saturation.

Reset
REQ-028 nrst=0 SHALL, asynchronously and at any time including mid-operation, force state to IDLE and busy, done, s, cy, neg, err and all internal registers to 0.
REQ-029 An operation interrupted by reset SHALL be abandoned and SHALL never produce done.

Configuration
REQ-030 With macro BCD_SIGNED_EN defined, the FIX state and the neg output SHALL be compiled in, and negative subtractions SHALL return sign-magnitude results.
REQ-031 Without BCD_SIGNED_EN, FIX SHALL be omitted, neg SHALL be tied to 0, and a negative subtraction SHALL return the raw 10's-complement value with cy=1.

Verification (DIGITS=4)
REQ-032 a=1234, b=5678, op=0 -> s=6912, cy=0, err=0, done exactly 6 edges after start.
REQ-033 a=9999, b=0001, op=0 -> s=0000, cy=1; then a=5000, b=1234, op=1 -> s=3766, cy=0, neg=0.
REQ-034 a=1234, b=5000, op=1 -> without macro: s=6234, cy=1, neg=0, done at edge 6; with macro: s=3766, cy=1, neg=1, done at edge 10.
REQ-035 a=12A4 (hex digit A), b=0000 -> err=1, s=0000, cy=0, done at edge 2; next valid operation -> err returns to 0.
REQ-036 Pulse start again at edge 3 of an operation -> ignored, original result unchanged; assert nrst=0 at edge 4 -> busy=0 and s=0 immediately, no done pulse.
